// File: rtl/float32_pkg.sv
// Shared binary32 field widths, converter FSM states and the normalisation step
// used by fix_to_float32.
package float32_pkg;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    typedef enum logic [2:0] {
        IDLE,
        NORM16,
        NORM8,
        NORM4,
        NORM2,
        NORM1,
        RND_OUT
    } state_t;

    typedef struct packed {
        logic [31:0] mag;
        logic [4:0]  shift;
    } norm_t;

    // One binary-search normalisation step: shift left by sh when the top sh bits are clear.
    function automatic norm_t norm_step(input logic [31:0] mag, input logic [4:0] shift,
                                        input logic [4:0] sh);
        norm_t r;
        r.mag   = mag;
        r.shift = shift;
        if ((mag >> (6'd32 - {1'b0, sh})) == 32'd0) begin
            r.mag   = mag << sh;
            r.shift = shift + sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa; a mantissa carry-out bumps the exponent.
module fp_round_rne
    import float32_pkg::*;
(
    input  logic [MAN_W-1:0] mant,
    input  logic             guard,
    input  logic             sticky,
    input  logic [EXP_W:0]   exp,
    output logic [MAN_W-1:0] rounded_mant,
    output logic [EXP_W:0]   rounded_exp
);

    logic           round_up;
    logic [MAN_W:0] sum;

    // On carry-out the low MAN_W bits of sum are already zero.
    always_comb begin
        round_up     = guard & (sticky | mant[0]);
        sum          = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        rounded_mant = sum[MAN_W-1:0];
        rounded_exp  = exp + {{EXP_W{1'b0}}, sum[MAN_W]};
    end

endmodule

// File: rtl/fix_to_float32.sv
// Sequential fixed-point to IEEE-754 binary32 converter: latch, 5-step normalise,
// round-to-nearest-even, then hold the result until the downstream handshake.
module fix_to_float32
    import float32_pkg::*;
#(
    parameter int unsigned FRAC_W = 0,
    parameter bit          SIGNED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [8:0] EXP_TOP = 9'(BIAS + 31 - FRAC_W);

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  shift;
    logic        neg;
    logic [4:0]  norm_sh;
    norm_t       step;
    logic [8:0]  exp_pre;
    logic [8:0]  rounded_exp;
    logic [22:0] rounded_mant;

    assign in_ready = (state == IDLE);
    assign neg      = SIGNED && in_data[31];
    assign exp_pre  = EXP_TOP - {4'b0, shift};

    always_comb begin
        norm_sh = 5'd0;
        case (state)
            NORM16:  norm_sh = 5'd16;
            NORM8:   norm_sh = 5'd8;
            NORM4:   norm_sh = 5'd4;
            NORM2:   norm_sh = 5'd2;
            NORM1:   norm_sh = 5'd1;
            default: norm_sh = 5'd0;
        endcase
        step = norm_step(mag, shift, norm_sh);
    end

    fp_round_rne u_round (
        .mant         (mag[30:8]),
        .guard        (mag[7]),
        .sticky       (|mag[6:0]),
        .exp          (exp_pre),
        .rounded_mant (rounded_mant),
        .rounded_exp  (rounded_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= neg;
                        mag   <= neg ? -in_data : in_data;
                        shift <= '0;
                        state <= NORM16;
                    end
                end
                NORM16: begin mag <= step.mag; shift <= step.shift; state <= NORM8;   end
                NORM8:  begin mag <= step.mag; shift <= step.shift; state <= NORM4;   end
                NORM4:  begin mag <= step.mag; shift <= step.shift; state <= NORM2;   end
                NORM2:  begin mag <= step.mag; shift <= step.shift; state <= NORM1;   end
                NORM1:  begin mag <= step.mag; shift <= step.shift; state <= RND_OUT; end
                RND_OUT: begin
                    // First RND_OUT cycle registers the result; later cycles hold it.
                    if (!out_valid) begin
                        out_data  <= (mag == '0) ? '0 : {sign, rounded_exp[7:0], rounded_mant};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Exponent stays within 96..159 for every legal FRAC_W, so bit 8 never sets.
    a_exp_range : assert property (@(posedge clk) disable iff (reset)
        (state == RND_OUT && !out_valid && mag != '0) |-> !rounded_exp[8]);

endmodule

// File: tb/tb_fix_to_float32.sv
// Bench for fix_to_float32: three parameterisations run in lockstep on shared stimulus
// and are checked against an arithmetic round-to-nearest-even model.
module tb_fix_to_float32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] od [3];
    logic        ir [3];
    logic        ov [3];

    int          tests_run = 0;
    int          fails = 0;
    int          cycle = 0;
    int          frac_cfg [3] = '{0, 0, 16};
    bit          sgn_cfg  [3] = '{1'b0, 1'b1, 1'b0};

    logic [31:0] got [3];
    int          lat;
    int          acc_cycle;

    typedef struct {
        logic [31:0] x;
        int          inst;
        logic [31:0] e;
    } dir_t;

    dir_t dv [9] = '{
        '{32'h0000_0001, 0, 32'h3F80_0000},
        '{32'h0000_0000, 0, 32'h0000_0000},
        '{32'h0100_0001, 0, 32'h4B80_0000},
        '{32'hFFFF_FFFF, 0, 32'h4F80_0000},
        '{32'hFFFF_FFFF, 1, 32'hBF80_0000},
        '{32'h8000_0000, 1, 32'hCF00_0000},
        '{32'h0000_0000, 1, 32'h0000_0000},
        '{32'h0001_0000, 2, 32'h3F80_0000},
        '{32'h0001_8000, 2, 32'h3FC0_0000}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    fix_to_float32 #(.FRAC_W(0), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready));
    fix_to_float32 #(.FRAC_W(0), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready));
    fix_to_float32 #(.FRAC_W(16), .SIGNED(0)) dut_f (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready));

    // Value = x * 2^-frac; find the MSB, keep 24 significant bits, round half to even.
    function automatic logic [31:0] model(input logic [31:0] x, input int frac, input bit sgn);
        bit              neg;
        longint unsigned v, q, rem, half;
        int              p, e, sh;
        neg = sgn && x[31];
        v = neg ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (((v >> i) & 1) != 0) p = i;
        e = p + 127 - frac;
        if (p <= 23) begin
            q = v << (23 - p);
        end else begin
            sh   = p - 23;
            q    = v >> sh;
            rem  = v - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {neg, 8'(e), q[22:0]};
    endfunction

    task automatic convert(input logic [31:0] x);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        in_valid  = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (ov[0]) begin
                lat = c;
                break;
            end
        end
        for (int i = 0; i < 3; i++) got[i] = od[i];
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || od[i] !== 32'h0) begin
                fails++;
                $display("FAIL reset inst=%0d got ir=%b ov=%b od=%h exp ir=1 ov=0 od=00000000",
                         i, ir[i], ov[i], od[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] e;
        out_ready = 1'b1;
        foreach (dv[k]) begin
            convert(dv[k].x);
            tests_run++;
            if (lat !== 6) begin
                fails++;
                $display("FAIL dir_latency x=%h got=%0d exp=6", dv[k].x, lat);
            end
            tests_run++;
            if (got[dv[k].inst] !== dv[k].e) begin
                fails++;
                $display("FAIL dir_value inst=%0d x=%h got=%h exp=%h",
                         dv[k].inst, dv[k].x, got[dv[k].inst], dv[k].e);
            end
            for (int i = 0; i < 3; i++) begin
                e = model(dv[k].x, frac_cfg[i], sgn_cfg[i]);
                tests_run++;
                if (got[i] !== e) begin
                    fails++;
                    $display("FAIL dir_model inst=%0d x=%h got=%h exp=%h", i, dv[k].x, got[i], e);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, e;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case (k % 3)
                0:       x = $urandom;
                1:       x = $urandom >> $urandom_range(0, 31);
                default: x = $urandom_range(0, 255);
            endcase
            convert(x);
            tests_run++;
            if (lat !== 6) begin
                fails++;
                $display("FAIL rand_latency x=%h got=%0d exp=6", x, lat);
            end
            for (int i = 0; i < 3; i++) begin
                e = model(x, frac_cfg[i], sgn_cfg[i]);
                tests_run++;
                if (got[i] !== e) begin
                    fails++;
                    $display("FAIL rand_value inst=%0d x=%h got=%h exp=%h", i, x, got[i], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        out_ready = 1'b1;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            convert($urandom);
            if (prev >= 0) begin
                tests_run++;
                if (acc_cycle - prev !== 8) begin
                    fails++;
                    $display("FAIL b2b_period got=%0d exp=8", acc_cycle - prev);
                end
            end
            prev = acc_cycle;
            @(posedge clk);
            #1;
            tests_run++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_drain got ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, held, e;
        int          pulses;
        @(negedge clk);
        out_ready = 1'b0;
        x = 32'h0012_3457;
        convert(x);
        held = got[0];
        e = model(x, 0, 1'b0);
        tests_run++;
        if (held !== e) begin
            fails++;
            $display("FAIL bp_value got=%h exp=%h", held, e);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_data  = 32'hDEAD_BEEF;
            in_valid = 1'b1;
            tests_run++;
            if (od[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle=%0d got od=%h ov=%b ir=%b exp od=%h ov=1 ir=0",
                         c, od[0], ov[0], ir[0], held);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]);
        end
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov[0]) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL bp_second_accepted got=%0d pulses exp=0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y, e;
        int          pulses;
        out_ready = 1'b1;
        @(negedge clk);
        in_data  = 32'h0000_BEEF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ov[i] !== 1'b0 || od[i] !== 32'h0 || ir[i] !== 1'b1) begin
                fails++;
                $display("FAIL rst_mid inst=%0d got ov=%b od=%h ir=%b exp ov=0 od=00000000 ir=1",
                         i, ov[i], od[i], ir[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ov[0]) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL rst_mid_stray got=%0d pulses exp=0", pulses);
        end
        // Reset while holding a result under backpressure.
        @(negedge clk);
        out_ready = 1'b0;
        convert(32'h0000_0300);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (ov[0] !== 1'b0 || od[0] !== 32'h0 || ir[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst_hold got ov=%b od=%h ir=%b exp ov=0 od=00000000 ir=1",
                     ov[0], od[0], ir[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        y = 32'h8765_4321;
        convert(y);
        tests_run++;
        if (lat !== 6) begin
            fails++;
            $display("FAIL rst_after_latency got=%0d exp=6", lat);
        end
        for (int i = 0; i < 3; i++) begin
            e = model(y, frac_cfg[i], sgn_cfg[i]);
            tests_run++;
            if (got[i] !== e) begin
                fails++;
                $display("FAIL rst_after_value inst=%0d got=%h exp=%h", i, got[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fix_to_float32.md
# fix_to_float32

Sequential fixed-point to IEEE-754 single-precision converter. It sits downstream of `op_amp_with_frac` and turns the 32-bit `square_out` amplitude result into a binary32 word for the float side of the converter datapath. It uses a valid/ready handshake on both ports, handles one conversion at a time, and rounds to nearest, ties to even.

## Interface
Parameters:
- `FRAC_W`, default 0: number of fractional bits in `in_data`. The value is `in_data * 2^-FRAC_W`. Legal range is 0..31.
- `SIGNED`, default 0: 0 means `in_data` is unsigned; 1 means `in_data` is two's complement.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `in_data`  in  32: fixed-point operand.
- `in_valid`  in  1: operand is valid.
- `in_ready`  out  1: block can accept an operand.
- `out_data`  out  32: binary32 result.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: downstream accepts the result.

## Operation
- The FSM has three phases: IDLE, NORM (5 sub-steps, sh=16,8,4,2,1), and RND_OUT.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: latch sign and magnitude, set shift count s=0, and go to NORM step 16.
  - When `SIGNED`=0: sign=0 and magnitude=in_data.
  - When `SIGNED`=1: sign=in_data[31] and magnitude=|in_data|. 0x80000000 gives magnitude 2^31 with no overflow.
- **NORM step sh:**
  - If the top sh bits of the magnitude are zero: shift the magnitude left by sh and add sh to s.
  - Steps run in order 16,8,4,2,1, one per cycle, always all five.
- **RND_OUT:**
  - After NORM, m[31] is the leading one (unless the magnitude is zero).
  - Fields: mant=m[30:8], guard=m[7], sticky=|m[6:0].
  - Exponent: exp = 127 + 31 - s - FRAC_W, computed at 9 bits.
  - Round up when guard & (sticky | mant[0]).
  - If rounding carries out of mant: mant=0 and exp+1.
  - Register out_data={sign,exp[7:0],mant} and set `out_valid`=1.
- **Zero input:** the result is 0x00000000, or 0x00000000 when `SIGNED` with input 0. No -0 is ever produced. Latency is unchanged.
- **Range:** with the legal `FRAC_W` range, exp stays within 96..159. No overflow, denormal, Inf or NaN path is needed.
- **Hold:** `out_data` and `out_valid` stay stable until `out_valid`&`out_ready`. On that edge `out_valid` drops and the FSM returns to IDLE.
- **In-flight operands:** `in_valid` is ignored while `in_ready`=0. The upstream must hold its operand until accepted.

## Timing
- **Accept** happens at the edge where `in_valid`&`in_ready`=1; call it edge k.
  - NORM runs at edges k+1..k+5.
  - The result is registered at edge k+6, so `out_valid` is high from k+6: a fixed 6-cycle latency.
- **Drain:** with `out_ready` held high, `out_valid` lasts one cycle. `in_ready` rises the cycle after the output handshake. Peak throughput is one conversion per 8 cycles.
- **`in_ready`** is decoded combinationally from the state and is 1 exactly in IDLE.
- **Reset values:**
  - state=IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_data`=0.
  - All working registers are 0.
- **Reset mid-conversion or mid-hold:** the result is abandoned and no `out_valid` pulse appears after reset deasserts.
- **`out_ready` while `out_valid`=0:** no effect.

## Structure
- **Package `float32_pkg`** holds:
  - constants BIAS=127, EXP_W=8, MAN_W=23;
  - the state enum {IDLE, NORM16, NORM8, NORM4, NORM2, NORM1, RND_OUT}.
- **Sub-module `fp_round_rne`:** combinational. Inputs are mant[22:0], guard, sticky and exp[8:0]; outputs are the rounded mant and exp. It is instantiated once in RND_OUT.
- Expected RTL size is about 200 lines in total.

## Test plan
- **Unsigned integer values** (`FRAC_W`=0, `SIGNED`=0):
  - in 1 → 0x3F800000, with `out_valid` exactly 6 cycles after accept.
  - in 0 → 0x00000000.
- **Rounding:**
  - 0x01000001 (a tie) → 0x4B800000, rounded to even.
  - 0xFFFFFFFF → mantissa carry → 0x4F800000.
- **Signed values** (`SIGNED`=1): 0xFFFFFFFF → 0xBF800000; 0x80000000 → 0xCF000000.
- **Fractional values** (`FRAC_W`=16): 0x00010000 → 0x3F800000; 0x00018000 → 0x3FC00000.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles: `out_data` is stable, `in_ready`=0, and a second `in_valid` is not accepted.
  - Release `out_ready`: one handshake occurs, then `in_ready`=1 the next cycle.
- **Reset mid-operation:** assert `reset` at accept+3.
  - Immediately: `out_valid`=0, `out_data`=0, `in_ready`=1.
  - After release: no stray result appears, and the next operand converts correctly.
